// File: rtl/ct_f_spsram_pkg.sv
// Shared types and helpers for the parametrised single-port SRAM wrapper.
// Holds the fill-engine state encoding and the geometry/configuration helpers.
package ct_f_spsram_pkg;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } spsram_state_t;

   function automatic int num_grp(input int data_w, input int grp_w);
      return data_w / grp_w;
   endfunction

   // A configuration is legal only when groups tile the data bus exactly
   // and the output stage count is 0 or 1.
   function automatic bit cfg_ok(input int data_w, input int grp_w, input int out_reg);
      return (grp_w > 0) && ((data_w % grp_w) == 0) && (out_reg == 0 || out_reg == 1);
   endfunction

endpackage

// File: rtl/ct_f_ram_bwe.sv
// Inferred single-port block RAM with per-group write enables and a registered read port.
// Reads and writes are mutually exclusive; the output holds when no read is issued.
module ct_f_ram_bwe #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 14,
   parameter int GRP_WIDTH  = 8,
   parameter int NUM_GRP    = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  rd_en,
   input  logic [NUM_GRP-1:0]    we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge CLK) begin
      for (int g = 0; g < NUM_GRP; g++) begin
         if (we[g]) mem[addr][g*GRP_WIDTH +: GRP_WIDTH] <= din[g*GRP_WIDTH +: GRP_WIDTH];
      end
   end

   // Stage 1: read register, cleared by reset, held on writes and idle cycles
   always_ff @(posedge CLK) begin
      if (RST)        dout <= '0;
      else if (rd_en) dout <= mem[addr];
   end

endmodule

// File: rtl/ct_f_spsram_bwe_init.sv
// Single-port SRAM wrapper with group write masking, optional output register and
// a post-reset fill engine that writes INIT_VALUE to every entry before user access.
module ct_f_spsram_bwe_init
   import ct_f_spsram_pkg::*;
#(
   parameter int                    DATA_WIDTH = 128,
   parameter int                    ADDR_WIDTH = 14,
   parameter int                    GRP_WIDTH  = 8,
   parameter int                    OUT_REG    = 0,
   parameter int                    INIT_EN    = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [ADDR_WIDTH-1:0] A,
   input  logic                  CEN,
   input  logic                  GWEN,
   input  logic [DATA_WIDTH-1:0] WEN,
   input  logic [DATA_WIDTH-1:0] D,
   output logic [DATA_WIDTH-1:0] Q,
   output logic                  INIT_BUSY
);

   localparam int NUM_GRP = num_grp(DATA_WIDTH, GRP_WIDTH);

   if (!cfg_ok(DATA_WIDTH, GRP_WIDTH, OUT_REG)) begin : g_cfg_err
      $error("ct_f_spsram_bwe_init: DATA_WIDTH must be a multiple of GRP_WIDTH and OUT_REG must be 0 or 1");
   end

   spsram_state_t         state_q, state_d;
   logic [ADDR_WIDTH-1:0] fill_cnt_q;
   logic [ADDR_WIDTH-1:0] a_hold_q;
   logic [NUM_GRP-1:0]    grp_we;
   logic [NUM_GRP-1:0]    ram_we;
   logic                  ram_rd;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_din;
   logic [DATA_WIDTH-1:0] q_p1;
   logic                  unused_wen;

   // Only the lowest bit of each mask group is significant
   always_comb begin
      grp_we = '0;
      for (int g = 0; g < NUM_GRP; g++) grp_we[g] = ~WEN[g*GRP_WIDTH];
   end
   assign unused_wen = ^WEN;

   always_ff @(posedge CLK) begin
      if (RST) state_q <= (INIT_EN != 0) ? ST_INIT : ST_READY;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (state_q == ST_INIT && fill_cnt_q == '1) state_d = ST_READY;
   end

   // The fill engine owns the port while busy; user inputs are ignored until READY
   always_comb begin
      INIT_BUSY = (state_q == ST_INIT);
      ram_we    = '0;
      ram_rd    = 1'b0;
      ram_addr  = a_hold_q;
      ram_din   = D;
      if (!RST) begin
         if (state_q == ST_INIT) begin
            ram_we   = '1;
            ram_addr = fill_cnt_q;
            ram_din  = INIT_VALUE;
         end else if (!CEN) begin
            ram_addr = A;
            if (GWEN) ram_rd = 1'b1;
            else      ram_we = grp_we;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST)                    fill_cnt_q <= '0;
      else if (state_q == ST_INIT) fill_cnt_q <= fill_cnt_q + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (!RST && state_q == ST_READY && !CEN) a_hold_q <= A;
   end

   ct_f_ram_bwe #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .GRP_WIDTH  (GRP_WIDTH),
      .NUM_GRP    (NUM_GRP)
   ) u_ram (
      .CLK   (CLK),
      .RST   (RST),
      .rd_en (ram_rd),
      .we    (ram_we),
      .addr  (ram_addr),
      .din   (ram_din),
      .dout  (q_p1)
   );

   // Stage 2: optional output register, shifts stage 1 every cycle
   if (OUT_REG == 1) begin : g_oreg
      logic [DATA_WIDTH-1:0] q_p2;
      always_ff @(posedge CLK) begin
         if (RST) q_p2 <= '0;
         else     q_p2 <= q_p1;
      end
      assign Q = q_p2;
   end else begin : g_noreg
      assign Q = q_p1;
   end

endmodule

// File: tb/tb_ct_f_spsram_bwe_init.sv
// Directed scoreboard bench: one DUT per output-latency flavour plus an INIT_EN=0 build,
// all driven by the same vectors; expected Q/INIT_BUSY are queued per cycle and checked by a monitor.
module tb_ct_f_spsram_bwe_init;

   localparam logic [31:0] IV = 32'hA5A5A5A5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  a = '0;
   logic        cen = 1'b1;
   logic        gwen = 1'b1;
   logic [31:0] wen = '1;
   logic [31:0] d = '0;
   logic [31:0] q0, q1, q2;
   logic        b0, b1, b2;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [31:0] q0;
      logic [31:0] q1;
      logic        busy;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   ct_f_spsram_bwe_init #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .GRP_WIDTH(8), .OUT_REG(0),
                          .INIT_EN(1), .INIT_VALUE(IV)) u_dut0 (
      .CLK(clk), .RST(rst), .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen), .D(d),
      .Q(q0), .INIT_BUSY(b0));

   ct_f_spsram_bwe_init #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .GRP_WIDTH(8), .OUT_REG(1),
                          .INIT_EN(1), .INIT_VALUE(IV)) u_dut1 (
      .CLK(clk), .RST(rst), .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen), .D(d),
      .Q(q1), .INIT_BUSY(b1));

   ct_f_spsram_bwe_init #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .GRP_WIDTH(8), .OUT_REG(0),
                          .INIT_EN(0), .INIT_VALUE(IV)) u_dut2 (
      .CLK(clk), .RST(rst), .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen), .D(d),
      .Q(q2), .INIT_BUSY(b2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: one queued expectation per clock edge, sampled 1 time unit after the edge
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("q_lat1",   q0, e.q0);
         chk("q_lat2",   q1, e.q1);
         chk("busy_lat1", {31'b0, b0}, {31'b0, e.busy});
         chk("busy_lat2", {31'b0, b1}, {31'b0, e.busy});
         chk("busy_noinit", {31'b0, b2}, 32'd0);
      end
   end

   task automatic step(input logic r, input logic c, input logic g, input logic [31:0] w,
                       input logic [3:0] ad, input logic [31:0] dd,
                       input logic [31:0] e0, input logic [31:0] e1, input logic eb);
      exp_t e;
      rst = r; cen = c; gwen = g; wen = w; a = ad; d = dd;
      e.q0 = e0; e.q1 = e1; e.busy = eb;
      sb.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic rd(input logic [3:0] ad, input logic [31:0] e0, input logic [31:0] e1);
      step(1'b0, 1'b0, 1'b1, '1, ad, 32'h0BAD0BAD, e0, e1, 1'b0);
   endtask

   task automatic wr(input logic [3:0] ad, input logic [31:0] dd, input logic [31:0] w,
                     input logic [31:0] e0, input logic [31:0] e1);
      step(1'b0, 1'b0, 1'b0, w, ad, dd, e0, e1, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #2;
      // Reset, partial fill, then reset again mid-fill
      repeat (2) step(1'b1, 1'b1, 1'b1, '1, 4'd0, '0, '0, '0, 1'b1);
      for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b1, '1, 4'd0, '0, '0, '0, 1'b1);
      step(1'b1, 1'b1, 1'b1, '1, 4'd0, '0, '0, '0, 1'b1);
      // Full fill; a write to addr 3 at fill cycle 5 must be ignored
      for (int k = 0; k < 16; k++) begin
         if (k == 5) step(1'b0, 1'b0, 1'b0, '0, 4'd3, 32'h12345678, '0, '0, 1'b1);
         else        step(1'b0, 1'b1, 1'b1, '1, 4'd0, '0, '0, '0, k < 15);
      end
      rd(4'd0,  IV, 32'h0);
      rd(4'd15, IV, IV);
      rd(4'd3,  IV, IV);
      // Masked writes: only groups whose LSB mask bit is 0 take D
      wr(4'd2, 32'h11223344, 32'h00000000, IV, IV);
      wr(4'd2, 32'hFFFFFFFF, 32'hFFFE01FE, IV, IV);
      wr(4'd2, 32'h00000000, 32'hFFFFFFFF, IV, IV);
      rd(4'd2, 32'h11FF33FF, IV);
      // Latency and hold; idle cycles carry write-like inputs that must not act
      wr(4'd7, 32'hDEADBEEF, 32'h0, 32'h11FF33FF, 32'h11FF33FF);
      rd(4'd7, 32'hDEADBEEF, 32'h11FF33FF);
      repeat (5) step(1'b0, 1'b1, 1'b0, '0, 4'd7, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
      // No-change write between reads of the same address
      rd(4'd1, IV, 32'hDEADBEEF);
      wr(4'd1, 32'hCAFEF00D, 32'h0, IV, IV);
      rd(4'd1, 32'hCAFEF00D, IV);
      // Back-to-back reads of different addresses
      rd(4'd2, 32'h11FF33FF, 32'hCAFEF00D);
      rd(4'd7, 32'hDEADBEEF, 32'h11FF33FF);
      rd(4'd1, 32'hCAFEF00D, 32'hDEADBEEF);
      step(1'b0, 1'b1, 1'b1, '1, 4'd9, '0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
      // Reset from READY re-runs the fill and overwrites user data
      step(1'b1, 1'b1, 1'b1, '1, 4'd0, '0, '0, '0, 1'b1);
      for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 1'b1, '1, 4'd0, '0, '0, '0, k < 15);
      rd(4'd2, IV, 32'h0);
      step(1'b0, 1'b1, 1'b1, '1, 4'd0, '0, IV, IV, 1'b0);
      #5;
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
